// File: rtl/icb_acc_bridge.sv
// ICB slave bridge to an accelerator: CSR window (start/base/status/cycle counter)
// and a byte-enabled synchronous SRAM window, with busy lockout and sticky-done IRQ.
module icb_acc_bridge #(
   parameter int unsigned SRAM_DW    = 64,
   parameter int unsigned SRAM_DEPTH = 4096,
   parameter int unsigned WIN_BIT    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          icb_cmd_valid,
   output logic                          icb_cmd_ready,
   input  logic                          icb_cmd_read,
   input  logic [31:0]                   icb_cmd_addr,
   input  logic [31:0]                   icb_cmd_wdata,
   input  logic [3:0]                    icb_cmd_wmask,
   output logic                          icb_rsp_valid,
   input  logic                          icb_rsp_ready,
   output logic [31:0]                   icb_rsp_rdata,
   output logic                          icb_rsp_err,
   output logic                          acc_start,
   input  logic                          acc_done,
   output logic [31:0]                   acc_input_base,
   output logic [31:0]                   acc_output_base,
   output logic                          sram_en,
   output logic                          sram_we,
   output logic [SRAM_DW/8-1:0]          sram_be,
   output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr,
   output logic [SRAM_DW-1:0]            sram_wdata,
   input  logic [SRAM_DW-1:0]            sram_rdata,
   output logic                          irq
);

   localparam int unsigned BE_W   = SRAM_DW / 8;
   localparam int unsigned AW     = $clog2(SRAM_DEPTH);
   localparam int unsigned OFF_W  = $clog2(BE_W);
   localparam int unsigned LANES  = SRAM_DW / 32;
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned WORD_W = WIN_BIT - OFF_W;

   localparam int unsigned OFF_CTRL   = 32'h00;
   localparam int unsigned OFF_STATUS = 32'h04;
   localparam int unsigned OFF_INB    = 32'h08;
   localparam int unsigned OFF_OUTB   = 32'h0C;
   localparam int unsigned OFF_CYC    = 32'h10;
   localparam int unsigned OFF_PARAM  = 32'h14;

   localparam logic [31:0] PARAM_VAL = {8'(AW), 8'(BE_W), 16'h0002};

   typedef enum logic [1:0] {IDLE, SRD, RSP} state_t;

   state_t              state;
   logic                busy;
   logic                done;
   logic                irq_en;
   logic [31:0]         cycles;
   logic [LANE_W-1:0]   rd_lane;

   logic [WIN_BIT-1:0]  off_c;
   logic [WORD_W-1:0]   word_c;
   logic [LANE_W-1:0]   lane_c;
   logic                sram_win_c;
   logic                in_range_c;
   logic                sram_ok_c;
   logic                accept_c;
   logic [31:0]         csr_rdata_c;
   logic                csr_err_c;
   logic [31:0]         rd_word_c;
   logic                unused_ok;

   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  m);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // Address decode of the presented command
   assign off_c      = icb_cmd_addr[WIN_BIT-1:0];
   assign word_c     = WORD_W'(off_c >> OFF_W);
   assign lane_c     = LANE_W'((icb_cmd_addr >> 2) % LANES);
   assign sram_win_c = icb_cmd_addr[WIN_BIT];
   assign in_range_c = 32'(word_c) < SRAM_DEPTH;
   assign sram_ok_c  = sram_win_c & in_range_c & ~busy;
   assign accept_c   = icb_cmd_valid & (state == IDLE);
   assign unused_ok  = ^{icb_cmd_addr[31:WIN_BIT+1], icb_cmd_addr[1:0]};

   assign icb_cmd_ready = (state == IDLE);

   // SRAM strobes are issued in the accept cycle so read data lands one cycle later
   assign sram_en    = accept_c & sram_ok_c;
   assign sram_we    = sram_en & ~icb_cmd_read;
   assign sram_be    = sram_we ? (BE_W'(icb_cmd_wmask) << (32'(lane_c) * 32'd4)) : '0;
   assign sram_addr  = AW'(word_c);
   assign sram_wdata = {LANES{icb_cmd_wdata}};

   always_comb begin
      rd_word_c = '0;
      for (int l = 0; l < LANES; l++) begin
         if (LANE_W'(l) == rd_lane) rd_word_c = sram_rdata[32*l +: 32];
      end
   end

   // CSR read mux and error decode
   always_comb begin
      csr_rdata_c = '0;
      csr_err_c   = 1'b0;
      case (32'(off_c))
         OFF_CTRL: begin
            csr_rdata_c = {30'd0, irq_en, 1'b0};
            csr_err_c   = ~icb_cmd_read & icb_cmd_wmask[0] & icb_cmd_wdata[0] & busy;
         end
         OFF_STATUS: csr_rdata_c = {30'd0, done, busy};
         OFF_INB:    csr_rdata_c = acc_input_base;
         OFF_OUTB:   csr_rdata_c = acc_output_base;
         OFF_CYC:    csr_rdata_c = cycles;
         OFF_PARAM:  csr_rdata_c = PARAM_VAL;
         default:    csr_err_c   = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         icb_rsp_valid   <= 1'b0;
         icb_rsp_rdata   <= '0;
         icb_rsp_err     <= 1'b0;
         acc_start       <= 1'b0;
         irq             <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         irq_en          <= 1'b0;
         cycles          <= '0;
         acc_input_base  <= '0;
         acc_output_base <= '0;
         rd_lane         <= '0;
      end else begin
         acc_start <= 1'b0;
         irq       <= done & irq_en;

         // Run tracking; a START write below can only fire while not busy
         if (busy) begin
            if (cycles != '1) cycles <= cycles + 32'd1;
            if (acc_done) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (icb_cmd_valid) begin
                  if (sram_win_c) begin
                     if (sram_ok_c && icb_cmd_read) begin
                        rd_lane <= lane_c;
                        state   <= SRD;
                     end else begin
                        icb_rsp_valid <= 1'b1;
                        icb_rsp_err   <= ~sram_ok_c;
                        icb_rsp_rdata <= '0;
                        state         <= RSP;
                     end
                  end else begin
                     icb_rsp_valid <= 1'b1;
                     icb_rsp_err   <= csr_err_c;
                     icb_rsp_rdata <= (icb_cmd_read && !csr_err_c) ? csr_rdata_c : '0;
                     state         <= RSP;
                     if (!icb_cmd_read) begin
                        case (32'(off_c))
                           OFF_CTRL: begin
                              if (icb_cmd_wmask[0]) begin
                                 irq_en <= icb_cmd_wdata[1];
                                 if (icb_cmd_wdata[0] && !busy) begin
                                    acc_start <= 1'b1;
                                    busy      <= 1'b1;
                                    done      <= 1'b0;
                                    cycles    <= '0;
                                 end
                              end
                           end
                           // A done pulse in the same cycle keeps DONE set
                           OFF_STATUS: begin
                              if (icb_cmd_wmask[0] && icb_cmd_wdata[1] && !(busy && acc_done))
                                 done <= 1'b0;
                           end
                           OFF_INB:  acc_input_base  <= merge_bytes(acc_input_base, icb_cmd_wdata, icb_cmd_wmask);
                           OFF_OUTB: acc_output_base <= merge_bytes(acc_output_base, icb_cmd_wdata, icb_cmd_wmask);
                           default: ;
                        endcase
                     end
                  end
               end
            end
            SRD: begin
               icb_rsp_valid <= 1'b1;
               icb_rsp_err   <= 1'b0;
               icb_rsp_rdata <= rd_word_c;
               state         <= RSP;
            end
            RSP: begin
               if (icb_rsp_ready) begin
                  icb_rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icb_acc_bridge.sv
// Bench for icb_acc_bridge: byte-level behavioural model with per-cycle output compare,
// plus directed transactions with hand-computed expectations.
module tb_icb_acc_bridge;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [31:0] icb_cmd_addr, icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [31:0] icb_rsp_rdata;
   logic        acc_start, acc_done;
   logic [31:0] acc_input_base, acc_output_base;
   logic        sram_en, sram_we;
   logic [7:0]  sram_be;
   logic [11:0] sram_addr;
   logic [63:0] sram_wdata;
   logic [63:0] sram_rdata = '0;
   logic        irq;

   int errors = 0;
   int checks = 0;

   icb_acc_bridge #(.SRAM_DW(64), .SRAM_DEPTH(4096), .WIN_BIT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
      .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
      .acc_start(acc_start), .acc_done(acc_done),
      .acc_input_base(acc_input_base), .acc_output_base(acc_output_base),
      .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous SRAM attached to the bridge
   logic [63:0] sram_mem [0:4095];
   always @(posedge clk) begin
      if (sram_en) begin
         for (int b = 0; b < 8; b++)
            if (sram_we && sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         sram_rdata <= sram_mem[sram_addr];
      end
   end

   // Behavioural model: byte-addressed SRAM image and CSR state; m_ph 0=free, 1=read pending, 2=responding
   logic [7:0]  mb [0:32767];
   int          m_ph = 0;
   logic [31:0] m_rdata = '0, m_cycles = '0, m_in = '0, m_out = '0;
   logic        m_err = 0, m_busy = 0, m_done = 0, m_irq_en = 0, m_irq = 0, m_start = 0;
   int          n_ph, bo, base;
   logic [31:0] n_rdata, n_cycles, n_in, n_out;
   logic        n_err, n_busy, n_done, n_irq_en, n_start;

   initial begin
      for (int i = 0; i < 4096; i++) sram_mem[i] = '0;
      for (int i = 0; i < 32768; i++) mb[i] = '0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_rdata = '0; m_err = 0; m_busy = 0; m_done = 0; m_irq_en = 0;
         m_irq = 0; m_start = 0; m_cycles = '0; m_in = '0; m_out = '0;
      end else begin
         n_ph = m_ph; n_rdata = m_rdata; n_err = m_err; n_busy = m_busy; n_done = m_done;
         n_irq_en = m_irq_en; n_cycles = m_cycles; n_in = m_in; n_out = m_out; n_start = 0;
         if (m_busy && m_cycles != 32'hFFFF_FFFF) n_cycles = m_cycles + 1;
         if (m_ph == 2) begin
            if (icb_rsp_ready) n_ph = 0;
         end else if (m_ph == 1) begin
            n_ph = 2;
         end else if (icb_cmd_valid) begin
            n_ph = 2; n_rdata = '0; n_err = 0;
            if (icb_cmd_addr[16]) begin
               bo = int'(icb_cmd_addr[15:0]);
               base = (bo / 4) * 4;
               if (m_busy || bo / 8 >= DEPTH) n_err = 1;
               else if (icb_cmd_read) begin
                  n_ph = 1;
                  n_rdata = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
               end else begin
                  for (int i = 0; i < 4; i++)
                     if (icb_cmd_wmask[i]) mb[base+i] = icb_cmd_wdata[8*i +: 8];
               end
            end else begin
               case (icb_cmd_addr[15:0])
                  16'h00: if (icb_cmd_read) n_rdata = {30'd0, m_irq_en, 1'b0};
                          else if (icb_cmd_wmask[0]) begin
                             n_irq_en = icb_cmd_wdata[1];
                             if (icb_cmd_wdata[0]) begin
                                if (m_busy) n_err = 1;
                                else begin n_start = 1; n_busy = 1; n_done = 0; n_cycles = 0; end
                             end
                          end
                  16'h04: if (icb_cmd_read) n_rdata = {30'd0, m_done, m_busy};
                          else if (icb_cmd_wmask[0] && icb_cmd_wdata[1]) n_done = 0;
                  16'h08: if (icb_cmd_read) n_rdata = m_in;
                          else for (int i = 0; i < 4; i++)
                             if (icb_cmd_wmask[i]) n_in[8*i +: 8] = icb_cmd_wdata[8*i +: 8];
                  16'h0C: if (icb_cmd_read) n_rdata = m_out;
                          else for (int i = 0; i < 4; i++)
                             if (icb_cmd_wmask[i]) n_out[8*i +: 8] = icb_cmd_wdata[8*i +: 8];
                  16'h10: if (icb_cmd_read) n_rdata = m_cycles;
                  16'h14: if (icb_cmd_read) n_rdata = 32'h0C08_0002;
                  default: n_err = 1;
               endcase
            end
         end
         // Done pulse applied last so it wins over a coincident W1C
         if (m_busy && acc_done) begin n_busy = 0; n_done = 1; end
         m_irq = m_done & m_irq_en;
         m_ph = n_ph; m_rdata = n_rdata; m_err = n_err; m_busy = n_busy; m_done = n_done;
         m_irq_en = n_irq_en; m_cycles = n_cycles; m_in = n_in; m_out = n_out; m_start = n_start;
      end
   end

   // Per-cycle compare of every output against the model
   logic        cmp_on = 0;
   logic        c_exp_en;
   logic [7:0]  c_eb;
   int          en_count = 0;
   logic [7:0]  cap_be;
   logic [11:0] cap_addr;
   logic [63:0] cap_wdata;

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cmd_ready", icb_cmd_ready, m_ph == 0);
         chk("rsp_valid", icb_rsp_valid, m_ph == 2);
         if (m_ph == 2) begin
            chk("rsp_rdata", icb_rsp_rdata, m_rdata);
            chk("rsp_err", icb_rsp_err, m_err);
         end
         chk("acc_start", acc_start, m_start);
         chk("irq", irq, m_irq);
         chk("input_base", acc_input_base, m_in);
         chk("output_base", acc_output_base, m_out);
         c_exp_en = (m_ph == 0) && icb_cmd_valid && icb_cmd_addr[16] && !m_busy &&
                    (int'(icb_cmd_addr[15:3]) < DEPTH);
         chk("sram_en", sram_en, c_exp_en);
         if (c_exp_en) begin
            chk("sram_we", sram_we, !icb_cmd_read);
            chk("sram_addr", sram_addr, icb_cmd_addr[14:3]);
            if (!icb_cmd_read) begin
               c_eb = {4'b0, icb_cmd_wmask};
               if (icb_cmd_addr[2]) c_eb = c_eb << 4;
               chk("sram_be", sram_be, c_eb);
               chk("sram_wdata", sram_wdata, {icb_cmd_wdata, icb_cmd_wdata});
            end
         end
         if (sram_en) begin
            en_count++;
            cap_be = sram_be; cap_addr = sram_addr; cap_wdata = sram_wdata;
         end
      end
   end

   task automatic icb(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] wm, input int hold, input logic with_done,
                      output logic [31:0] rdata, output logic err, output int lat);
      int n;
      rdata = '0; err = 1'b0; lat = 0;
      icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
      icb_cmd_wdata = wd; icb_cmd_wmask = wm; icb_rsp_ready = (hold == 0);
      acc_done = with_done;
      n = 0;
      do begin @(negedge clk); n++; end while (!icb_cmd_ready && n < 20);
      if (!icb_cmd_ready) begin
         checks++; errors++;
         $display("FAIL cmd_accept_timeout: addr 0x%0h not accepted, required within 20 cycles", addr);
      end
      @(posedge clk); #1;
      icb_cmd_valid = 1'b0; acc_done = 1'b0;
      while (1) begin
         @(negedge clk); lat++;
         if (icb_rsp_valid || lat >= 10) break;
      end
      if (!icb_rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_timeout: addr 0x%0h no response, required within 10 cycles", addr);
      end
      rdata = icb_rsp_rdata; err = icb_rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", icb_rsp_valid, 1'b1);
         chk("hold_rdata", icb_rsp_rdata, rdata);
         chk("hold_cmd_ready", icb_cmd_ready, 1'b0);
      end
      icb_rsp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lt, en0, n;

   initial begin
      rst_n = 1'b0; icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = '0;
      icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 0; acc_done = 0;
      @(posedge clk); #1;
      cmp_on = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_rsp_valid", icb_rsp_valid, 1'b0);
      chk("reset_cmd_ready", icb_cmd_ready, 1'b1);

      // PARAM and SRAM byte-lane write/readback
      icb(1, 32'h14, 0, 0, 0, 0, rd, er, lt);
      chk("param", rd, 32'h0C08_0002); chk("param_lat", lt, 1);
      icb(0, 32'h0001_0004, 32'hAABB_CCDD, 4'b0101, 0, 0, rd, er, lt);
      chk("wr_be", cap_be, 8'h50); chk("wr_wdata", cap_wdata, 64'hAABBCCDD_AABBCCDD);
      chk("wr_addr", cap_addr, 12'd0); chk("wr_lat", lt, 1); chk("wr_err", er, 0);
      icb(1, 32'h0001_0004, 0, 0, 0, 0, rd, er, lt);
      chk("rd_lane1", rd, 32'h00BB_00DD); chk("rd_lat", lt, 2);
      icb(0, 32'h0001_0010, 32'h1122_3344, 4'hF, 0, 0, rd, er, lt);
      chk("wr2_be", cap_be, 8'h0F); chk("wr2_addr", cap_addr, 12'd2);
      icb(1, 32'h0001_0010, 0, 0, 0, 0, rd, er, lt);
      chk("rd_word2", rd, 32'h1122_3344);

      // Byte-masked base CSRs
      icb(0, 32'h08, 32'h1234_5678, 4'hF, 0, 0, rd, er, lt);
      icb(0, 32'h08, 32'hFFFF_FFFF, 4'b0010, 0, 0, rd, er, lt);
      icb(1, 32'h08, 0, 0, 0, 0, rd, er, lt); chk("inbase", rd, 32'h1234_FF78);
      icb(0, 32'h0C, 32'hCAFE_F00D, 4'b1001, 0, 0, rd, er, lt);
      icb(1, 32'h0C, 0, 0, 0, 0, rd, er, lt); chk("outbase", rd, 32'hCA00_000D);

      // Start, busy lockout
      icb(0, 32'h00, 32'h3, 4'h1, 0, 0, rd, er, lt); chk("start_err", er, 0);
      icb(1, 32'h04, 0, 0, 0, 0, rd, er, lt); chk("status_busy", rd, 32'h1);
      en0 = en_count;
      icb(1, 32'h0001_0004, 0, 0, 0, 0, rd, er, lt);
      chk("busy_rd_err", er, 1); chk("busy_rd_data", rd, 0); chk("busy_rd_lat", lt, 1);
      icb(0, 32'h0001_0008, 32'h5555_5555, 4'hF, 0, 0, rd, er, lt); chk("busy_wr_err", er, 1);
      chk("busy_no_sram_en", en_count, en0);
      icb(0, 32'h00, 32'h1, 4'h1, 0, 0, rd, er, lt); chk("restart_err", er, 1);
      icb(1, 32'h00, 0, 0, 0, 0, rd, er, lt); chk("ctrl_irqen0", rd, 32'h0);
      icb(0, 32'h00, 32'h2, 4'h1, 0, 0, rd, er, lt); chk("irqen_wr_err", er, 0);
      icb(1, 32'h00, 0, 0, 0, 0, rd, er, lt); chk("ctrl_irqen1", rd, 32'h2);

      // Done after 100 busy cycles
      n = 0;
      while (m_cycles != 99 && n < 300) begin @(posedge clk); #1; n++; end
      acc_done = 1'b1; @(posedge clk); #1; acc_done = 1'b0;
      icb(1, 32'h04, 0, 0, 0, 0, rd, er, lt); chk("status_done", rd, 32'h2);
      icb(1, 32'h10, 0, 0, 0, 0, rd, er, lt); chk("cycles", rd, 32'd100);
      @(negedge clk); chk("irq_set", irq, 1);
      @(posedge clk); #1;
      icb(0, 32'h04, 32'h2, 4'h1, 0, 0, rd, er, lt);
      @(posedge clk); #1; @(negedge clk); chk("irq_clr", irq, 0);
      @(posedge clk); #1;
      acc_done = 1'b1; @(posedge clk); #1; acc_done = 1'b0;
      icb(1, 32'h04, 0, 0, 0, 0, rd, er, lt); chk("status_idle_done", rd, 32'h0);

      // Response back-pressure
      icb(1, 32'h10, 0, 0, 5, 0, rd, er, lt); chk("hold_cycles", rd, 32'd100);
      icb(1, 32'h08, 0, 0, 0, 0, rd, er, lt); chk("after_hold", rd, 32'h1234_FF78);
      chk("after_hold_lat", lt, 1);

      // Error decode and coincident W1C/done
      icb(1, 32'h18, 0, 0, 0, 0, rd, er, lt); chk("bad_csr_err", er, 1); chk("bad_csr_data", rd, 0);
      icb(1, 32'h0001_8000, 0, 0, 0, 0, rd, er, lt); chk("oor_err", er, 1); chk("oor_data", rd, 0);
      icb(0, 32'h00, 32'h1, 4'h1, 0, 0, rd, er, lt); chk("start2_err", er, 0);
      icb(0, 32'h04, 32'h2, 4'h1, 0, 1, rd, er, lt);
      icb(1, 32'h04, 0, 0, 0, 0, rd, er, lt); chk("done_beats_w1c", rd, 32'h2);

      // Reset in the middle of an SRAM read
      icb(0, 32'h00, 32'h2, 4'h1, 0, 0, rd, er, lt);
      @(negedge clk); chk("irq_pre_reset", irq, 1);
      @(posedge clk); #1;
      icb_cmd_valid = 1; icb_cmd_read = 1; icb_cmd_addr = 32'h0001_0004; icb_rsp_ready = 1;
      @(posedge clk); #1;
      icb_cmd_valid = 0; rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", icb_rsp_valid, 0); chk("rst_acc_start", acc_start, 0);
      chk("rst_irq", irq, 0); chk("rst_inbase", acc_input_base, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      icb(1, 32'h00, 0, 0, 0, 0, rd, er, lt); chk("rst_ctrl", rd, 0);
      icb(1, 32'h04, 0, 0, 0, 0, rd, er, lt); chk("rst_status", rd, 0);
      icb(1, 32'h0001_0004, 0, 0, 0, 0, rd, er, lt); chk("rst_sram_kept", rd, 32'h00BB_00DD);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

endmodule
